// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcode/funct encodings, ALU codes and state/class enums for mc_controller
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BLEQ  = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SEQ  = 6'b101000;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_SEQ  = 4'b1010;
    localparam logic [3:0] ALU_BLEQ = 4'b1011;
    localparam logic [3:0] ALU_MFHI = 4'b1100;
    localparam logic [3:0] ALU_MFLO = 4'b1101;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, MDU_WAIT, TRAP} state_e;

    typedef enum logic [2:0] {CL_RALU, CL_IMM, CL_LW, CL_SW, CL_BR, CL_J, CL_MDU, CL_NONE} class_e;

endpackage

// File: rtl/mc_instr_class.sv
// mc_instr_class: combinational opcode/funct classifier producing class, ALU code, unsigned-imm flag and legality
module mc_instr_class import mc_ctrl_pkg::*; (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output class_e     cls,
    output logic [3:0] alu,
    output logic       imm_u,
    output logic       legal
);

    always_comb begin
        cls   = CL_NONE;
        alu   = ALU_AND;
        imm_u = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                cls = CL_RALU;
                case (funct)
                    FN_ADD, FN_ADDU: alu = ALU_ADD;
                    FN_SUB:          alu = ALU_SUB;
                    FN_AND:          alu = ALU_AND;
                    FN_OR:           alu = ALU_OR;
                    FN_XOR:          alu = ALU_XOR;
                    FN_NOR:          alu = ALU_NOR;
                    FN_SLL:          alu = ALU_SLL;
                    FN_SRL:          alu = ALU_SRL;
                    FN_SRA:          alu = ALU_SRA;
                    FN_SLT:          alu = ALU_SLT;
                    FN_SEQ:          alu = ALU_SEQ;
                    FN_MFHI:         alu = ALU_MFHI;
                    FN_MFLO:         alu = ALU_MFLO;
                    FN_MULT, FN_DIV: cls = CL_MDU;
                    default:         cls = CL_NONE;
                endcase
            end
            OP_ADDI: begin cls = CL_IMM; alu = ALU_ADD; end
            OP_ANDI: begin cls = CL_IMM; alu = ALU_AND; imm_u = 1'b1; end
            OP_ORI:  begin cls = CL_IMM; alu = ALU_OR;  imm_u = 1'b1; end
            OP_XORI: begin cls = CL_IMM; alu = ALU_XOR; imm_u = 1'b1; end
            OP_LW:   begin cls = CL_LW;  alu = ALU_ADD; end
            OP_SW:   begin cls = CL_SW;  alu = ALU_ADD; end
            OP_BEQ:  begin cls = CL_BR;  alu = ALU_SUB; end
            OP_BLEQ: begin cls = CL_BR;  alu = ALU_BLEQ; end
            OP_J:    cls = CL_J;
            default: cls = CL_NONE;
        endcase
        legal = cls != CL_NONE;
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with MDU handshake and trap; MC_CONTROLLER_PERF_EN adds perf counters
module mc_controller import mc_ctrl_pkg::*; #(
    parameter int ALUC_W      = 4,
    parameter int MEM_LAT     = 1,
    parameter int MDU_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              mdu_done,
    output logic              instr_req,
    output logic              ir_write,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic              reg_dst,
    output logic              alu_src,
    output logic              mem_to_reg,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              branch,
    output logic              jump,
    output logic              is_imm_unsigned,
    output logic [ALUC_W-1:0] alu_control,
    output logic              mdu_start,
    output logic              mdu_op,
    output logic              hilo_write,
    output logic              trap,
    output logic              trap_cause
`ifdef MC_CONTROLLER_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_instret
`endif
);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [5:0] op_q, op_d, fn_q, fn_d;
    logic       cause_q, cause_d;
    class_e     cls;
    logic [3:0] alu;
    logic       imm_u, legal;

    mc_instr_class u_class (
        .opcode (op_q),
        .funct  (fn_q),
        .cls    (cls),
        .alu    (alu),
        .imm_u  (imm_u),
        .legal  (legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            op_q    <= '0;
            fn_q    <= '0;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = '0;
        op_d            = op_q;
        fn_d            = fn_q;
        cause_d         = cause_q;
        instr_req       = 1'b0;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        pc_write_cond   = 1'b0;
        reg_dst         = 1'b0;
        alu_src         = 1'b0;
        mem_to_reg      = 1'b0;
        reg_write       = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        branch          = 1'b0;
        jump            = 1'b0;
        is_imm_unsigned = 1'b0;
        alu_control     = '0;
        mdu_start       = 1'b0;
        mdu_op          = 1'b0;
        hilo_write      = 1'b0;
        trap            = 1'b0;
        trap_cause      = 1'b0;
        case (state_q)
            FETCH: begin
                instr_req = 1'b1;
                ir_write  = instr_valid;
                pc_write  = instr_valid;
                op_d      = instr_valid ? opcode : op_q;
                fn_d      = instr_valid ? funct : fn_q;
                state_d   = instr_valid ? DECODE : FETCH;
            end
            DECODE: begin
                state_d = legal ? EXEC : TRAP;
                cause_d = legal ? cause_q : 1'b0;
            end
            EXEC: begin
                alu_control = ALUC_W'(alu);
                case (cls)
                    CL_RALU: state_d = WB;
                    CL_IMM:  begin alu_src = 1'b1; state_d = WB; end
                    CL_LW, CL_SW: begin alu_src = 1'b1; state_d = MEM; end
                    CL_BR:   begin branch = 1'b1; pc_write_cond = 1'b1; state_d = FETCH; end
                    CL_J:    begin jump = 1'b1; pc_write = 1'b1; state_d = FETCH; end
                    CL_MDU:  begin mdu_start = 1'b1; mdu_op = fn_q[1]; state_d = MDU_WAIT; end
                    default: state_d = TRAP;
                endcase
            end
            MEM: begin
                mem_read  = cls == CL_LW;
                mem_write = cls == CL_SW;
                if (cnt_q == 8'(MEM_LAT - 1))
                    state_d = (cls == CL_LW) ? WB : FETCH;
                else
                    cnt_d = cnt_q + 8'd1;
            end
            WB: begin
                reg_write       = 1'b1;
                mem_to_reg      = cls == CL_LW;
                reg_dst         = cls == CL_RALU;
                alu_src         = cls == CL_IMM;
                is_imm_unsigned = imm_u;
                state_d         = FETCH;
            end
            MDU_WAIT: begin
                mdu_op = fn_q[1];
                // done takes priority over an expiring watchdog in the same cycle
                if (mdu_done) begin
                    hilo_write = 1'b1;
                    state_d    = FETCH;
                end else if (cnt_q == 8'(MDU_TIMEOUT - 1)) begin
                    state_d = TRAP;
                    cause_d = 1'b1;
                end else
                    cnt_d = cnt_q + 8'd1;
            end
            TRAP: begin
                trap       = 1'b1;
                trap_cause = cause_q;
            end
            default: state_d = FETCH;
        endcase
        if (rst)
            {instr_req, ir_write, pc_write, pc_write_cond, reg_dst, alu_src, mem_to_reg, reg_write,
             mem_read, mem_write, branch, jump, is_imm_unsigned, alu_control, mdu_start, mdu_op,
             hilo_write, trap, trap_cause} = '0;
    end

`ifdef MC_CONTROLLER_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d, perf_instret_q, perf_instret_d;
    logic        retire;

    always_comb begin
        retire         = (state_d == FETCH) && (state_q inside {EXEC, MEM, WB, MDU_WAIT});
        perf_cycles_d  = perf_cycles_q + ((state_q != TRAP) ? 32'd1 : 32'd0);
        perf_instret_d = perf_instret_q + (retire ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_q  <= '0;
            perf_instret_q <= '0;
        end else begin
            perf_cycles_q  <= perf_cycles_d;
            perf_instret_q <= perf_instret_d;
        end
    end

    assign perf_cycles  = rst ? '0 : perf_cycles_q;
    assign perf_instret = rst ? '0 : perf_instret_q;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for mc_controller with MEM_LAT=3, MDU_TIMEOUT=8
module tb_mc_controller;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst, instr_valid, mdu_done;
    logic [5:0] opcode, funct;
    logic       instr_req, ir_write, pc_write, pc_write_cond, reg_dst, alu_src, mem_to_reg, reg_write;
    logic       mem_read, mem_write, branch, jump, is_imm_unsigned, mdu_start, mdu_op, hilo_write;
    logic       trap, trap_cause;
    logic [3:0] alu_control;
`ifdef MC_CONTROLLER_PERF_EN
    logic [31:0] perf_cycles, perf_instret;
`endif

    mc_controller #(.ALUC_W(4), .MEM_LAT(3), .MDU_TIMEOUT(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .instr_valid     (instr_valid),
        .opcode          (opcode),
        .funct           (funct),
        .mdu_done        (mdu_done),
        .instr_req       (instr_req),
        .ir_write        (ir_write),
        .pc_write        (pc_write),
        .pc_write_cond   (pc_write_cond),
        .reg_dst         (reg_dst),
        .alu_src         (alu_src),
        .mem_to_reg      (mem_to_reg),
        .reg_write       (reg_write),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .branch          (branch),
        .jump            (jump),
        .is_imm_unsigned (is_imm_unsigned),
        .alu_control     (alu_control),
        .mdu_start       (mdu_start),
        .mdu_op          (mdu_op),
        .hilo_write      (hilo_write),
        .trap            (trap),
        .trap_cause      (trap_cause)
`ifdef MC_CONTROLLER_PERF_EN
        ,
        .perf_cycles     (perf_cycles),
        .perf_instret    (perf_instret)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [21:0] REQ  = 22'd1 << 21;
    localparam logic [21:0] IRW  = 22'd1 << 20;
    localparam logic [21:0] PCW  = 22'd1 << 19;
    localparam logic [21:0] PCC  = 22'd1 << 18;
    localparam logic [21:0] RDST = 22'd1 << 17;
    localparam logic [21:0] ASRC = 22'd1 << 16;
    localparam logic [21:0] M2R  = 22'd1 << 15;
    localparam logic [21:0] RW   = 22'd1 << 14;
    localparam logic [21:0] MR   = 22'd1 << 13;
    localparam logic [21:0] MW   = 22'd1 << 12;
    localparam logic [21:0] BR   = 22'd1 << 11;
    localparam logic [21:0] JMP  = 22'd1 << 10;
    localparam logic [21:0] IMMU = 22'd1 << 9;
    localparam logic [21:0] MST  = 22'd1 << 4;
    localparam logic [21:0] MOP  = 22'd1 << 3;
    localparam logic [21:0] HILO = 22'd1 << 2;
    localparam logic [21:0] TRP  = 22'd1 << 1;
    localparam logic [21:0] CAUS = 22'd1;

    function automatic logic [21:0] a(input logic [3:0] c);
        return {13'd0, c, 5'd0};
    endfunction

    logic [21:0] obs;
    assign obs = {instr_req, ir_write, pc_write, pc_write_cond, reg_dst, alu_src, mem_to_reg, reg_write,
                  mem_read, mem_write, branch, jump, is_imm_unsigned, alu_control, mdu_start, mdu_op,
                  hilo_write, trap, trap_cause};

    typedef struct {
        string       tag;
        logic [21:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk(mon_e.tag, 32'(obs), 32'(mon_e.v));
        end
    end

    task automatic step(input string tag, input logic [21:0] e, input logic v = 1'b0, input logic d = 1'b0);
        instr_valid = v;
        mdu_done    = d;
        sb.push_back('{tag, e});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
        step("fetch", REQ | IRW | PCW, 1'b1);
        opcode = '1;
        funct  = '1;
        step("decode", '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step("rst", '0, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; mdu_done = 1'b0; opcode = '0; funct = '0;
        @(posedge clk);
        #1;
        step("rst_a", '0, 1'b1);
        step("rst_b", '0);
        rst = 1'b0;
        step("idle", REQ);
        fetch(OP_RTYPE, FN_ADD);
        step("add_ex", a(ALU_ADD));
        step("add_wb", RW | RDST);
        fetch(OP_ORI, 6'd0);
        step("ori_ex", ASRC | a(ALU_OR));
        step("ori_wb", RW | ASRC | IMMU);
        fetch(OP_RTYPE, FN_SRA);
        step("sra_ex", a(ALU_SRA));
        step("sra_wb", RW | RDST);
        fetch(OP_LW, 6'd0);
        step("lw_ex", ASRC | a(ALU_ADD));
        repeat (3) step("lw_mem", MR);
        step("lw_wb", RW | M2R);
        fetch(OP_SW, 6'd0);
        step("sw_ex", ASRC | a(ALU_ADD));
        repeat (3) step("sw_mem", MW);
        step("sw_after", REQ);
        fetch(OP_BEQ, 6'd0);
        step("beq_ex", BR | PCC | a(ALU_SUB));
        fetch(OP_BLEQ, 6'd0);
        step("bleq_ex", BR | PCC | a(ALU_BLEQ));
        fetch(OP_J, 6'd0);
        step("j_ex", JMP | PCW);
        step("idle_done", REQ, 1'b0, 1'b1);
        fetch(OP_RTYPE, FN_MULT);
        step("mult_ex", MST);
        repeat (4) step("mult_wait", '0);
        step("mult_done", HILO, 1'b0, 1'b1);
        fetch(OP_RTYPE, FN_MFHI);
        step("mfhi_ex", a(ALU_MFHI));
        step("mfhi_wb", RW | RDST);
        fetch(OP_RTYPE, FN_DIV);
        step("div_ex", MST | MOP);
        repeat (8) step("div_wait", MOP);
        repeat (3) step("trap_to", TRP | CAUS, 1'b1);
        do_reset();
        step("post_rst", REQ);
        fetch(6'b111111, 6'd0);
        repeat (3) step("trap_ill", TRP, 1'b1);
        do_reset();
        repeat (10) step("idle10", REQ);
        fetch(OP_SW, 6'd0);
        step("swa_ex", ASRC | a(ALU_ADD));
        step("swa_mem", MW);
        rst = 1'b1;
        step("swa_abort", '0);
        rst = 1'b0;
        step("swa_post", REQ);
`ifdef MC_CONTROLLER_PERF_EN
        do_reset();
        fetch(OP_RTYPE, FN_ADD);
        step("p_add_ex", a(ALU_ADD));
        step("p_add_wb", RW | RDST);
        fetch(OP_BEQ, 6'd0);
        step("p_beq_ex", BR | PCC | a(ALU_SUB));
        fetch(OP_J, 6'd0);
        step("p_j_ex", JMP | PCW);
        chk("perf_instret", perf_instret, 32'd3);
        chk("perf_cycles", perf_cycles, 32'd10);
`endif
        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
